// File: rtl/ddr_note_lanes.sv
// ddr_note_lanes: note lanes for a rhythm game.
// Each lane holds a circular buffer of falling note y coordinates. Player presses
// are judged against a judgement line. Once per frame every note advances, and
// notes that have passed the hit window are judged as misses.
// Ports:
//   clk_pix_i, rst_pix_i   pixel clock, synchronous active-high reset
//   frame_i                one-cycle pulse at the start of vertical blanking
//   spawn_i[LANES]         per-lane request to append a note at y=0
//   btn_i[LANES]           debounced button levels
//   spawn_drop_o[LANES]    pulse when a spawn is dropped because the lane is full
//   head_valid_o, head_y_o oldest note per lane (combinational; y is 0 when empty)
//   judge_valid_o/lane/o   registered judgement pulse (1=miss, 2=good, 3=perfect)
//   score_o, combo_o       saturating score and combo
module ddr_note_lanes #(
  parameter int LANES       = 4,
  parameter int DEPTH       = 8,
  parameter int CORDW       = 10,
  parameter int TARGET_Y    = 400,
  parameter int SPEED       = 4,
  parameter int HIT_WIN     = 16,
  parameter int PERFECT_WIN = 4,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk_pix_i,
  input  logic                   rst_pix_i,
  input  logic                   frame_i,
  input  logic [LANES-1:0]       spawn_i,
  input  logic [LANES-1:0]       btn_i,
  output logic [LANES-1:0]       spawn_drop_o,
  output logic [LANES-1:0]       head_valid_o,
  output logic [LANES*CORDW-1:0] head_y_o,
  output logic                   judge_valid_o,
  output logic [LW-1:0]          judge_lane_o,
  output logic [1:0]             judge_o,
  output logic [15:0]            score_o,
  output logic [7:0]             combo_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int IW = $clog2(LANES * DEPTH) + 1;

  localparam logic [CORDW:0]   TGT      = (CORDW+1)'(TARGET_Y);
  localparam logic [CORDW:0]   HIT_W    = (CORDW+1)'(HIT_WIN);
  localparam logic [CORDW:0]   PERF_W   = (CORDW+1)'(PERFECT_WIN);
  localparam logic [CORDW:0]   SPD      = (CORDW+1)'(SPEED);
  localparam logic [CORDW+1:0] MISS_LIM = (CORDW+2)'(TARGET_Y + HIT_WIN);

  localparam logic [1:0] J_MISS = 2'd1;
  localparam logic [1:0] J_GOOD = 2'd2;
  localparam logic [1:0] J_PERF = 2'd3;

  typedef enum logic [1:0] {IDLE, MOVE, MISS} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CORDW-1:0] mem_q [LANES][DEPTH];
  logic [CORDW-1:0] mem_d [LANES][DEPTH];
  logic [PW-1:0]    head_q [LANES];
  logic [PW-1:0]    head_d [LANES];
  logic [PW-1:0]    tail_q [LANES];
  logic [PW-1:0]    tail_d [LANES];
  logic [CW-1:0]    cnt_q [LANES];
  logic [CW-1:0]    cnt_d [LANES];
  logic [LANES-1:0] press_pend_q, press_pend_d;
  logic [LANES-1:0] spawn_pend_q, spawn_pend_d;
  logic [LANES-1:0] btn_prev_q, btn_prev_d;
  logic [LANES-1:0] spawn_drop_q, spawn_drop_d;
  logic             frame_pend_q, frame_pend_d;
  logic             judge_valid_q, judge_valid_d;
  logic [LW-1:0]    judge_lane_q, judge_lane_d;
  logic [1:0]       judge_q, judge_d;
  logic [15:0]      score_q, score_d;
  logic [7:0]       combo_q, combo_d;

  logic [CORDW-1:0] head_y_w [LANES];
  logic [LW-1:0]    press_sel;
  logic [CORDW:0]   press_dist;
  logic             press_hit;
  logic [LW-1:0]    mv_lane;
  logic [PW-1:0]    mv_slot;
  logic [PW-1:0]    mv_off;
  logic [CORDW:0]   mv_sum;
  logic [LW-1:0]    ms_lane;
  logic             ms_miss;
  logic [16:0]      score_sum;

  // Oldest note per lane; an empty lane reports y=0.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      head_y_w[l] = (cnt_q[l] != '0) ? mem_q[l][head_q[l]] : '0;
      head_valid_o[l] = (cnt_q[l] != '0);
      head_y_o[l*CORDW +: CORDW] = head_y_w[l];
    end
  end

  // Press servicing: pick the lowest pending lane and measure its head distance to the line.
  always_comb begin
    press_sel = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (press_pend_q[l]) press_sel = LW'(l);
    end
    if ({1'b0, head_y_w[press_sel]} >= TGT) press_dist = {1'b0, head_y_w[press_sel]} - TGT;
    else                                    press_dist = TGT - {1'b0, head_y_w[press_sel]};
    press_hit = (cnt_q[press_sel] != '0) && (press_dist <= HIT_W);
  end

  // MOVE walks slots lane-major; a slot is occupied when its offset from head is below count.
  always_comb begin
    mv_lane = LW'(idx_q >> PW);
    mv_slot = idx_q[PW-1:0];
    mv_off  = mv_slot - head_q[mv_lane];
    mv_sum  = {1'b0, mem_q[mv_lane][mv_slot]} + SPD;
    ms_lane = LW'(idx_q);
    ms_miss = (cnt_q[ms_lane] != '0) && ({1'b0, {1'b0, head_y_w[ms_lane]}} > MISS_LIM);
  end

  // Next-state logic: a frame only starts the sweep once all presses are judged.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (frame_pend_q && (press_pend_q == '0)) begin
          state_d = MOVE;
          idx_d   = '0;
        end
      end
      MOVE: begin
        if (idx_q == IW'(LANES * DEPTH - 1)) begin
          state_d = MISS;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      MISS: begin
        if (idx_q == IW'(LANES - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Datapath and outputs. Pending bits are cleared when serviced and new events are
  // OR-ed in afterwards so an event arriving in the servicing cycle is kept.
  always_comb begin
    mem_d         = mem_q;
    head_d        = head_q;
    tail_d        = tail_q;
    cnt_d         = cnt_q;
    press_pend_d  = press_pend_q;
    spawn_pend_d  = spawn_pend_q;
    frame_pend_d  = frame_pend_q;
    btn_prev_d    = btn_i;
    spawn_drop_d  = '0;
    judge_valid_d = 1'b0;
    judge_lane_d  = judge_lane_q;
    judge_d       = judge_q;
    score_d       = score_q;
    combo_d       = combo_q;
    score_sum     = {1'b0, score_q};

    case (state_q)
      IDLE: begin
        for (int l = 0; l < LANES; l++) begin
          if (spawn_pend_q[l]) begin
            if (cnt_q[l] == CW'(DEPTH)) begin
              spawn_drop_d[l] = 1'b1;
            end else begin
              mem_d[l][tail_q[l]] = '0;
              tail_d[l] = tail_q[l] + PW'(1);
              cnt_d[l]  = cnt_q[l] + CW'(1);
            end
          end
        end
        spawn_pend_d = '0;
        if (press_pend_q != '0) begin
          press_pend_d[press_sel] = 1'b0;
          if (press_hit) begin
            // Applied on top of any spawn increment so a same-lane pop+spawn nets zero.
            head_d[press_sel] = head_q[press_sel] + PW'(1);
            cnt_d[press_sel]  = cnt_d[press_sel] - CW'(1);
            judge_valid_d = 1'b1;
            judge_lane_d  = press_sel;
            judge_d       = (press_dist <= PERF_W) ? J_PERF : J_GOOD;
          end
        end
        if (frame_pend_q && (press_pend_q == '0)) frame_pend_d = 1'b0;
      end
      MOVE: begin
        if ({1'b0, mv_off} < cnt_q[mv_lane]) begin
          mem_d[mv_lane][mv_slot] = mv_sum[CORDW] ? {CORDW{1'b1}} : mv_sum[CORDW-1:0];
        end
      end
      MISS: begin
        if (ms_miss) begin
          head_d[ms_lane] = head_q[ms_lane] + PW'(1);
          cnt_d[ms_lane]  = cnt_q[ms_lane] - CW'(1);
          judge_valid_d = 1'b1;
          judge_lane_d  = ms_lane;
          judge_d       = J_MISS;
        end
      end
      default: ;
    endcase

    press_pend_d = press_pend_d | (btn_i & ~btn_prev_q);
    spawn_pend_d = spawn_pend_d | spawn_i;
    frame_pend_d = frame_pend_d | frame_i;

    // Score and combo are registered alongside the judgement so they change together.
    if (judge_valid_d) begin
      if (judge_d == J_MISS) begin
        combo_d = '0;
      end else begin
        score_sum = {1'b0, score_q} + ((judge_d == J_PERF) ? 17'd3 : 17'd1);
        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        combo_d   = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_pix_i) begin
    if (rst_pix_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Control and output registers; button history resets high so a held button is not a press.
  always_ff @(posedge clk_pix_i) begin
    if (rst_pix_i) begin
      for (int l = 0; l < LANES; l++) begin
        head_q[l] <= '0;
        tail_q[l] <= '0;
        cnt_q[l]  <= '0;
      end
      press_pend_q  <= '0;
      spawn_pend_q  <= '0;
      frame_pend_q  <= 1'b0;
      btn_prev_q    <= '1;
      spawn_drop_q  <= '0;
      judge_valid_q <= 1'b0;
      judge_lane_q  <= '0;
      judge_q       <= '0;
      score_q       <= '0;
      combo_q       <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      cnt_q         <= cnt_d;
      press_pend_q  <= press_pend_d;
      spawn_pend_q  <= spawn_pend_d;
      frame_pend_q  <= frame_pend_d;
      btn_prev_q    <= btn_prev_d;
      spawn_drop_q  <= spawn_drop_d;
      judge_valid_q <= judge_valid_d;
      judge_lane_q  <= judge_lane_d;
      judge_q       <= judge_d;
      score_q       <= score_d;
      combo_q       <= combo_d;
    end
  end

  // Note storage needs no reset: slots outside [head, head+count) are never observed.
  always_ff @(posedge clk_pix_i) begin
    mem_q <= mem_d;
  end

  assign spawn_drop_o  = spawn_drop_q;
  assign judge_valid_o = judge_valid_q;
  assign judge_lane_o  = judge_lane_q;
  assign judge_o       = judge_q;
  assign score_o       = score_q;
  assign combo_o       = combo_q;

endmodule

// File: tb/tb_ddr_note_lanes.sv
// Self-checking bench for ddr_note_lanes. A lane-queue reference model predicts
// judgements and dropped spawns; a monitor pops those predictions when the DUT
// reports them. Directed scenarios are followed by a randomized phase.
module tb_ddr_note_lanes;

  localparam int LANES       = 4;
  localparam int DEPTH       = 8;
  localparam int CORDW       = 10;
  localparam int TARGET_Y    = 400;
  localparam int SPEED       = 4;
  localparam int HIT_WIN     = 16;
  localparam int PERFECT_WIN = 4;
  localparam int MAXY        = (1 << CORDW) - 1;
  localparam int FRAME_WAIT  = LANES * DEPTH + LANES + 12;

  logic                   clk_pix_i;
  logic                   rst_pix_i;
  logic                   frame_i;
  logic [LANES-1:0]       spawn_i;
  logic [LANES-1:0]       btn_i;
  logic [LANES-1:0]       spawn_drop_o;
  logic [LANES-1:0]       head_valid_o;
  logic [LANES*CORDW-1:0] head_y_o;
  logic                   judge_valid_o;
  logic [1:0]             judge_lane_o;
  logic [1:0]             judge_o;
  logic [15:0]            score_o;
  logic [7:0]             combo_o;

  ddr_note_lanes #(
    .LANES(LANES), .DEPTH(DEPTH), .CORDW(CORDW), .TARGET_Y(TARGET_Y),
    .SPEED(SPEED), .HIT_WIN(HIT_WIN), .PERFECT_WIN(PERFECT_WIN)
  ) dut (
    .clk_pix_i(clk_pix_i), .rst_pix_i(rst_pix_i), .frame_i(frame_i),
    .spawn_i(spawn_i), .btn_i(btn_i), .spawn_drop_o(spawn_drop_o),
    .head_valid_o(head_valid_o), .head_y_o(head_y_o),
    .judge_valid_o(judge_valid_o), .judge_lane_o(judge_lane_o), .judge_o(judge_o),
    .score_o(score_o), .combo_o(combo_o)
  );

  initial clk_pix_i = 1'b0;
  always #5 clk_pix_i = ~clk_pix_i;

  typedef struct {
    int lane;
    int code;
    int score;
    int combo;
  } judge_t;

  int     lane_model [LANES][$];
  judge_t judge_exp [$];
  int     drop_exp [$];
  int     model_score;
  int     model_combo;
  int     checks;
  int     errors;
  judge_t mon_e;
  int     mon_drop;
  int     score_before;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoring rules: perfect +3, good +1 (both extend the combo), miss resets combo.
  function automatic void model_judge(input int lane, input int code);
    judge_t e;
    if (code == 3) model_score = (model_score + 3 > 65535) ? 65535 : model_score + 3;
    if (code == 2) model_score = (model_score + 1 > 65535) ? 65535 : model_score + 1;
    if (code == 1) model_combo = 0;
    else           model_combo = (model_combo == 255) ? 255 : model_combo + 1;
    e.lane = lane; e.code = code; e.score = model_score; e.combo = model_combo;
    judge_exp.push_back(e);
  endfunction

  function automatic void model_spawn(input logic [LANES-1:0] mask);
    int drop;
    drop = 0;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) begin
        if (lane_model[l].size() < DEPTH) lane_model[l].push_back(0);
        else drop |= (1 << l);
      end
    end
    if (drop != 0) drop_exp.push_back(drop);
  endfunction

  function automatic void model_press(input logic [LANES-1:0] mask);
    int d;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l] && lane_model[l].size() > 0) begin
        d = lane_model[l][0] - TARGET_Y;
        if (d < 0) d = -d;
        if (d <= HIT_WIN) begin
          void'(lane_model[l].pop_front());
          model_judge(l, (d <= PERFECT_WIN) ? 3 : 2);
        end
      end
    end
  endfunction

  function automatic void model_frame();
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < lane_model[l].size(); i++) begin
        lane_model[l][i] = (lane_model[l][i] + SPEED > MAXY) ? MAXY : lane_model[l][i] + SPEED;
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (lane_model[l].size() > 0 && lane_model[l][0] > TARGET_Y + HIT_WIN) begin
        void'(lane_model[l].pop_front());
        model_judge(l, 1);
      end
    end
  endfunction

  task automatic checkHeads();
    for (int l = 0; l < LANES; l++) begin
      checkOutput($sformatf("head_valid[%0d]", l), int'(head_valid_o[l]),
                  (lane_model[l].size() > 0) ? 1 : 0);
      checkOutput($sformatf("head_y[%0d]", l), int'(head_y_o[l*CORDW +: CORDW]),
                  (lane_model[l].size() > 0) ? lane_model[l][0] : 0);
    end
    checkOutput("score", int'(score_o), model_score);
    checkOutput("combo", int'(combo_o), model_combo);
  endtask

  // One stimulus step: pulse the given inputs for a cycle, predict, then let the DUT settle.
  task automatic applyStimulus(input logic [LANES-1:0] spawn_mask,
                               input logic [LANES-1:0] press_mask, input bit frame);
    @(posedge clk_pix_i); #1;
    spawn_i = spawn_mask;
    btn_i   = press_mask;
    frame_i = frame;
    model_spawn(spawn_mask);
    model_press(press_mask);
    if (frame) model_frame();
    @(posedge clk_pix_i); #1;
    spawn_i = '0;
    btn_i   = '0;
    frame_i = 1'b0;
    repeat (frame ? FRAME_WAIT : LANES + 6) @(posedge clk_pix_i);
    #1;
    checkHeads();
  endtask

  task automatic runFrames(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_judge_valid"}, int'(judge_valid_o), 0);
    checkOutput({tag, "_spawn_drop"}, int'(spawn_drop_o), 0);
    checkOutput({tag, "_head_valid"}, int'(head_valid_o), 0);
    checkOutput({tag, "_score"}, int'(score_o), 0);
    checkOutput({tag, "_combo"}, int'(combo_o), 0);
  endtask

  // Monitor: every judgement or drop the DUT reports must match the oldest prediction.
  always @(negedge clk_pix_i) begin
    if (!rst_pix_i) begin
      if (judge_valid_o) begin
        if (judge_exp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_judge: got lane %0d code %0d, expected none",
                   judge_lane_o, judge_o);
        end else begin
          mon_e = judge_exp.pop_front();
          checkOutput("judge_lane", int'(judge_lane_o), mon_e.lane);
          checkOutput("judge_code", int'(judge_o), mon_e.code);
          checkOutput("judge_score", int'(score_o), mon_e.score);
          checkOutput("judge_combo", int'(combo_o), mon_e.combo);
        end
      end
      if (spawn_drop_o != '0) begin
        if (drop_exp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_drop: got mask %0d, expected none", spawn_drop_o);
        end else begin
          mon_drop = drop_exp.pop_front();
          checkOutput("spawn_drop", int'(spawn_drop_o), mon_drop);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    model_score = 0;
    model_combo = 0;
    rst_pix_i = 1'b1;
    frame_i = 1'b0;
    spawn_i = '0;
    btn_i = '0;
    repeat (3) @(posedge clk_pix_i);
    #1;
    rst_pix_i = 1'b0;
    checkResetState("reset");
    checkHeads();

    $display("[TB] perfect hit on lane 0");
    applyStimulus(4'b0001, '0, 1'b0);
    runFrames(100);
    applyStimulus('0, 4'b0001, 1'b0);
    checkOutput("perfect_score", int'(score_o), 3);
    checkOutput("perfect_combo", int'(combo_o), 1);
    checkOutput("perfect_head_valid0", int'(head_valid_o[0]), 0);

    $display("[TB] good hit and out-of-window press on lane 2");
    applyStimulus(4'b0100, '0, 1'b0);
    runFrames(97);
    applyStimulus('0, 4'b0100, 1'b0);
    checkOutput("good_score", int'(score_o), 4);
    applyStimulus(4'b0100, '0, 1'b0);
    runFrames(95);
    applyStimulus('0, 4'b0100, 1'b0);
    checkOutput("far_press_head_y2", int'(head_y_o[2*CORDW +: CORDW]), 380);

    $display("[TB] miss on lane 1");
    applyStimulus(4'b0010, '0, 1'b0);
    runFrames(105);
    checkOutput("miss_combo", int'(combo_o), 0);
    checkOutput("miss_head_valid1", int'(head_valid_o[1]), 0);

    $display("[TB] simultaneous presses with frame");
    applyStimulus(4'b0110, '0, 1'b0);
    runFrames(100);
    score_before = int'(score_o);
    applyStimulus('0, 4'b0110, 1'b1);
    checkOutput("dual_score_gain", int'(score_o) - score_before, 6);

    $display("[TB] overfill lane 3");
    for (int i = 0; i < 9; i++) applyStimulus(4'b1000, '0, 1'b0);
    checkOutput("full_head_y3", int'(head_y_o[3*CORDW +: CORDW]), 0);

    $display("[TB] reset during MOVE");
    @(posedge clk_pix_i); #1;
    frame_i = 1'b1;
    @(posedge clk_pix_i); #1;
    frame_i = 1'b0;
    repeat (10) @(posedge clk_pix_i);
    #1;
    rst_pix_i = 1'b1;
    @(posedge clk_pix_i); #1;
    rst_pix_i = 1'b0;
    checkOutput("reset_pending_judgements", judge_exp.size(), 0);
    for (int l = 0; l < LANES; l++) lane_model[l].delete();
    model_score = 0;
    model_combo = 0;
    checkResetState("midmove_reset");
    runFrames(5);

    $display("[TB] randomized phase");
    for (int i = 0; i < 350; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2)      applyStimulus(LANES'($urandom_range(1, 15)), '0, 1'b0);
      else if (r < 4) applyStimulus('0, LANES'($urandom_range(1, 15)), 1'b0);
      else            applyStimulus('0, '0, 1'b1);
    end

    repeat (5) @(posedge clk_pix_i);
    #1;
    checkOutput("leftover_judgements", judge_exp.size(), 0);
    checkOutput("leftover_drops", drop_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
